// File: rtl/tmr_reg_slave_pkg.sv
// Shared definitions for the timer register responder: register map, TSR bit
// positions, bus FSM encoding and the address error decode.
package tmr_reg_pkg;

  localparam logic [7:0] TMR_ADDR_TDR  = 8'h00;
  localparam logic [7:0] TMR_ADDR_TCR  = 8'h01;
  localparam logic [7:0] TMR_ADDR_TSR  = 8'h02;
  localparam logic [7:0] TMR_ADDR_TIER = 8'h03;
  localparam logic [7:0] TMR_ADDR_TCNT = 8'h04;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } tmr_state_e;

  // Unmapped addresses fail, as does any write to the read-only counter.
  function automatic logic addr_err(input logic [7:0] addr, input logic wr);
    return (addr > TMR_ADDR_TCNT) || (wr && (addr == TMR_ADDR_TCNT));
  endfunction

endpackage

// File: rtl/tmr_reg_slave_w1c_bit.sv
// Single status flag: set by a hardware pulse, cleared by software writing 1.
// When both happen in the same cycle the set wins so no event is lost.
module tmr_w1c_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= 1'b0;
    else if (set) q <= 1'b1;
    else if (clr) q <= 1'b0;
  end

endmodule

// File: rtl/tmr_reg_slave.sv
// APB-style register responder for the timer block (TDR, TCR, TSR, TIER, TCNT).
// Define TMR_APB_WAIT_EN to insert one wait state in every transfer.
module tmr_reg_slave
  import tmr_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic [7:0] tcnt,
  input  logic       ovf_set,
  input  logic       udf_set,
  output logic [7:0] tdr,
  output logic [7:0] tcr,
  output logic       tdr_load,
  output logic       irq
);

  tmr_state_e state;
  tmr_state_e phase;
  logic [1:0] tsr;
  logic [1:0] tier;
  logic [7:0] rd_mux;
  logic       capture;
  logic       err_now;
  logic       commit;

  // Bus phase of the current cycle; the registered state remembers the
  // previous phase so the registered handshake lines up with the bus.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    phase = ST_IDLE;
    case (state)
      ST_IDLE:   if (psel && !penable) phase = ST_SETUP;
      ST_SETUP:  if (psel) phase = penable ? ST_ACCESS : ST_SETUP;
      ST_ACCESS: if (psel) phase = ST_ACCESS;
      default:   phase = ST_IDLE;
    endcase
  end

`ifdef TMR_APB_WAIT_EN
  assign capture = (phase == ST_ACCESS) && !pready;
`else
  assign capture = (phase == ST_SETUP);
`endif

  assign err_now = addr_err(paddr, pwrite);
  assign commit  = psel && penable && pready && pwrite && !pslverr;

  always_comb begin
    rd_mux = 8'h00;
    case (paddr)
      TMR_ADDR_TDR:  rd_mux = tdr;
      TMR_ADDR_TCR:  rd_mux = tcr;
      TMR_ADDR_TSR:  rd_mux = {6'b0, tsr};
      TMR_ADDR_TIER: rd_mux = {6'b0, tier};
      TMR_ADDR_TCNT: rd_mux = tcnt;
      default:       rd_mux = 8'h00;
    endcase
  end

  // Handshake FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= 8'h00;
    end else begin
      state   <= (phase == ST_ACCESS && pready) ? ST_IDLE : phase;
      pready  <= capture;
      pslverr <= capture && err_now;
      prdata  <= (capture && !pwrite && !err_now) ? rd_mux : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr      <= 8'h00;
      tcr      <= 8'h00;
      tier     <= 2'b00;
      tdr_load <= 1'b0;
    end else begin
      tdr_load <= commit && (paddr == TMR_ADDR_TDR);
      if (commit) begin
        case (paddr)
          TMR_ADDR_TDR:  tdr  <= pwdata;
          TMR_ADDR_TCR:  tcr  <= pwdata;
          TMR_ADDR_TIER: tier <= pwdata[1:0];
          default:       ;
        endcase
      end
    end
  end

  tmr_w1c_bit u_tsr_ovf (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (ovf_set),
    .clr   (commit && (paddr == TMR_ADDR_TSR) && pwdata[TSR_OVF]),
    .q     (tsr[TSR_OVF])
  );

  tmr_w1c_bit u_tsr_udf (
    .clk   (clk),
    .rst_n (rst_n),
    .set   (udf_set),
    .clr   (commit && (paddr == TMR_ADDR_TSR) && pwdata[TSR_UDF]),
    .q     (tsr[TSR_UDF])
  );

  assign irq = |(tsr & tier);

endmodule

// File: tb/tb_tmr_reg_slave.sv
// Directed self-checking bench for tmr_reg_slave: register access, W1C status,
// interrupt, error responses, reset during a transfer and wait-state timing.
module tb_tmr_reg_slave;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic [7:0] tcnt;
  logic       ovf_set, udf_set;
  logic [7:0] tdr, tcr;
  logic       tdr_load, irq;

`ifdef TMR_APB_WAIT_EN
  localparam int EXP_WAITS = 1;
`else
  localparam int EXP_WAITS = 0;
`endif

  int n_tests  = 0;
  int n_fail   = 0;
  int load_cnt = 0;

  tmr_reg_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .tcnt     (tcnt),
    .ovf_set  (ovf_set),
    .udf_set  (udf_set),
    .tdr      (tdr),
    .tcr      (tcr),
    .tdr_load (tdr_load),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tdr_load) load_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transfer; ovf_in raises ovf_set in the completing cycle.
  task automatic bus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic ovf_in, output logic [7:0] rdata, output logic err,
                     output int waits);
    logic seen;
    seen  = 1'b0;
    waits = 0;
    rdata = 8'h00;
    err   = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (pready) seen = 1'b1;
      else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!seen) check("pready_timeout", {31'b0, pready}, 32'd1);
    rdata   = prdata;
    err     = pslverr;
    ovf_set = ovf_in;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; ovf_set = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       er;
    int         w;
    int         load0;

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00; tcnt = 8'h5A; ovf_set = 1'b0; udf_set = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_prdata",   prdata,   8'h00);
    check("rst_pready",   pready,   1'b0);
    check("rst_pslverr",  pslverr,  1'b0);
    check("rst_tdr",      tdr,      8'h00);
    check("rst_tcr",      tcr,      8'h00);
    check("rst_tdr_load", tdr_load, 1'b0);
    check("rst_irq",      irq,      1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // TDR write and read back, with the load pulse
    load0 = load_cnt;
    bus(1'b1, 8'h00, 8'hA5, 1'b0, rd, er, w);
    check("tdr_wr_err", er, 1'b0);
    check("tdr_wr_waits", w, EXP_WAITS);
    @(negedge clk);
    check("tdr_load_pulse", tdr_load, 1'b1);
    check("tdr_value", tdr, 8'hA5);
    bus(1'b0, 8'h00, 8'h00, 1'b0, rd, er, w);
    check("tdr_rd", rd, 8'hA5);
    check("tdr_rd_err", er, 1'b0);
    check("tdr_rd_waits", w, EXP_WAITS);
    check("tdr_load_once", load_cnt - load0, 1);

    // TCR and TIER
    bus(1'b1, 8'h01, 8'h3C, 1'b0, rd, er, w);
    bus(1'b0, 8'h01, 8'h00, 1'b0, rd, er, w);
    check("tcr_rd", rd, 8'h3C);
    check("tcr_out", tcr, 8'h3C);
    bus(1'b1, 8'h03, 8'hFF, 1'b0, rd, er, w);
    bus(1'b0, 8'h03, 8'h00, 1'b0, rd, er, w);
    check("tier_rd", rd, 8'h03);

    // Overflow flag, interrupt and W1C
    bus(1'b1, 8'h03, 8'h01, 1'b0, rd, er, w);
    @(negedge clk);
    check("irq_idle", irq, 1'b0);
    @(posedge clk); #1 ovf_set = 1'b1;
    @(posedge clk); #1 ovf_set = 1'b0;
    @(negedge clk);
    check("irq_ovf", irq, 1'b1);
    bus(1'b0, 8'h02, 8'h00, 1'b0, rd, er, w);
    check("tsr_ovf_rd", rd, 8'h01);
    bus(1'b1, 8'h02, 8'h01, 1'b0, rd, er, w);
    @(negedge clk);
    check("irq_cleared", irq, 1'b0);
    bus(1'b0, 8'h02, 8'h00, 1'b0, rd, er, w);
    check("tsr_cleared", rd, 8'h00);
    bus(1'b1, 8'h02, 8'h01, 1'b1, rd, er, w);
    bus(1'b0, 8'h02, 8'h00, 1'b0, rd, er, w);
    check("tsr_set_wins", rd, 8'h01);

    // Underflow flag is masked from irq by TIER but still visible
    @(posedge clk); #1 udf_set = 1'b1;
    @(posedge clk); #1 udf_set = 1'b0;
    bus(1'b0, 8'h02, 8'h00, 1'b0, rd, er, w);
    check("tsr_both", rd, 8'h03);
    bus(1'b1, 8'h02, 8'h03, 1'b0, rd, er, w);
    @(negedge clk);
    check("irq_all_clear", irq, 1'b0);

    // Counter read and error responses
    bus(1'b0, 8'h04, 8'h00, 1'b0, rd, er, w);
    check("tcnt_rd", rd, 8'h5A);
    check("tcnt_rd_err", er, 1'b0);
    bus(1'b0, 8'h07, 8'h00, 1'b0, rd, er, w);
    check("bad_rd_err", er, 1'b1);
    check("bad_rd_data", rd, 8'h00);
    load0 = load_cnt;
    bus(1'b1, 8'h04, 8'h55, 1'b0, rd, er, w);
    check("tcnt_wr_err", er, 1'b1);
    @(negedge clk);
    check("tcnt_wr_tdr", tdr, 8'hA5);
    check("tcnt_wr_tcr", tcr, 8'h3C);
    check("tcnt_wr_noload", load_cnt - load0, 0);

    // Reset during the access phase of a TDR write
    load0 = load_cnt;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h77;
    @(posedge clk); #1 penable = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tdr", tdr, 8'h00);
    check("mid_rst_pready", pready, 1'b0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_tdr_after", tdr, 8'h00);
    check("mid_rst_noload", load_cnt - load0, 0);
    bus(1'b0, 8'h00, 8'h00, 1'b0, rd, er, w);
    check("mid_rst_tdr_rd", rd, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
